// File: rtl/osc_pair_ctrl.sv
// osc_pair_ctrl: measurement controller for a pair of oscillator counters.
// Opens a shared gate for N clock cycles, then holds the gate low for C_SETTLE
// cycles so both measurement stages can publish their counts. It then captures
// both counts and reports which oscillator ran faster, and by how much.
//
// Handshake: I_start is a request. It is accepted only while the FSM is IDLE
// and I_win_len is non-zero. O_busy is high from acceptance until the capture.
// O_done is a one-cycle pulse marking the cycle in which the results first
// become valid. The results then hold until the next capture. A new I_start
// is accepted in the O_done cycle.
module osc_pair_ctrl #(
  parameter int C_DWIDTH = 24,
  parameter int C_WWIDTH = 16,
  parameter int C_SETTLE = 4
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_start,
  input  logic [C_WWIDTH-1:0] I_win_len,
  input  logic [C_DWIDTH-1:0] I_cnt_a,
  input  logic [C_DWIDTH-1:0] I_cnt_b,
  output logic                O_gate,
  output logic                O_busy,
  output logic                O_done,
  output logic                O_resp,
  output logic                O_tie,
  output logic [C_DWIDTH-1:0] O_diff,
  output logic [C_DWIDTH-1:0] O_cnt_a,
  output logic [C_DWIDTH-1:0] O_cnt_b,
  output logic [1:0]          O_state_dbg,
  output logic [C_WWIDTH-1:0] O_win_n_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // The settle counter runs from C_SETTLE-1 down to 0.
  // The capture happens on the edge where it reads 0.
  localparam logic [3:0]          SETTLE_LOAD = 4'(C_SETTLE - 1);
  localparam logic [C_WWIDTH-1:0] WIN_ONE     = C_WWIDTH'(1);

  state_t                state_q;
  logic [C_WWIDTH-1:0]   win_cnt_q;
  logic [C_WWIDTH-1:0]   win_n_q;
  logic [3:0]            settle_cnt_q;
  logic                  gate_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  resp_q;
  logic                  tie_q;
  logic [C_DWIDTH-1:0]   diff_q;
  logic [C_DWIDTH-1:0]   cnt_a_q;
  logic [C_DWIDTH-1:0]   cnt_b_q;

  logic                  resp_d;
  logic                  tie_d;
  logic [C_DWIDTH-1:0]   diff_d;

  // Unsigned comparison of the live stage counts.
  // Subtracting the smaller count from the larger one cannot overflow.
  always_comb begin
    resp_d = 1'b0;
    tie_d  = 1'b0;
    diff_d = '0;
    if (I_cnt_a > I_cnt_b) begin
      resp_d = 1'b1;
      diff_d = I_cnt_a - I_cnt_b;
    end else begin
      tie_d  = (I_cnt_a == I_cnt_b);
      diff_d = I_cnt_b - I_cnt_a;
    end
  end

  // Measurement FSM with registered gate, busy, done and result outputs.
  // The asynchronous reset drops the gate at once, which clears the stages.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q      <= ST_IDLE;
      win_cnt_q    <= '0;
      win_n_q      <= '0;
      settle_cnt_q <= '0;
      gate_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      resp_q       <= 1'b0;
      tie_q        <= 1'b0;
      diff_q       <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          gate_q <= 1'b0;
          busy_q <= 1'b0;
          // A zero-length window is not a measurement; drop it silently.
          if (I_start && (I_win_len != '0)) begin
            win_n_q   <= I_win_len;
            win_cnt_q <= I_win_len;
            gate_q    <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_WINDOW;
          end
        end
        ST_WINDOW: begin
          // The gate rose on the accepting edge.
          // It falls on the edge where the counter has reached 1, so it is
          // high for exactly N cycles.
          if (win_cnt_q == WIN_ONE) begin
            win_cnt_q    <= '0;
            gate_q       <= 1'b0;
            settle_cnt_q <= SETTLE_LOAD;
            state_q      <= ST_SETTLE;
          end else begin
            win_cnt_q <= win_cnt_q - WIN_ONE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == 4'd0) begin
            cnt_a_q <= I_cnt_a;
            cnt_b_q <= I_cnt_b;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
            diff_q  <= diff_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            settle_cnt_q <= settle_cnt_q - 4'd1;
          end
        end
        default: begin
          gate_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign O_gate      = gate_q;
  assign O_busy      = busy_q;
  assign O_done      = done_q;
  assign O_resp      = resp_q;
  assign O_tie       = tie_q;
  assign O_diff      = diff_q;
  assign O_cnt_a     = cnt_a_q;
  assign O_cnt_b     = cnt_b_q;
  assign O_state_dbg = state_q;
  assign O_win_n_dbg = win_n_q;

endmodule

// File: tb/tb_osc_pair_ctrl.sv
// tb_osc_pair_ctrl: directed scoreboard bench for osc_pair_ctrl.
// Expected results and gate widths are pushed when a measurement is issued.
// Monitors pop and compare them whenever the DUT presents O_done or ends a
// gate pulse.
module tb_osc_pair_ctrl;

  localparam int DW = 24;
  localparam int WW = 16;
  localparam int CS = 4;
  localparam int RW = 2 + 3 * DW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [WW-1:0] win_len;
  logic [DW-1:0] cnt_a;
  logic [DW-1:0] cnt_b;
  logic          o_gate, o_busy, o_done, o_resp, o_tie;
  logic [DW-1:0] o_diff, o_cnt_a, o_cnt_b;
  logic [1:0]    o_state;
  logic [WW-1:0] o_win_n;

  logic [RW-1:0] exp_q[$];
  int            gw_q[$];
  int            total = 0;
  int            bad   = 0;

  osc_pair_ctrl #(.C_DWIDTH(DW), .C_WWIDTH(WW), .C_SETTLE(CS)) dut (
    .I_clk(clk), .I_rst(rst), .I_start(start), .I_win_len(win_len),
    .I_cnt_a(cnt_a), .I_cnt_b(cnt_b),
    .O_gate(o_gate), .O_busy(o_busy), .O_done(o_done), .O_resp(o_resp),
    .O_tie(o_tie), .O_diff(o_diff), .O_cnt_a(o_cnt_a), .O_cnt_b(o_cnt_b),
    .O_state_dbg(o_state), .O_win_n_dbg(o_win_n)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result scoreboard: each O_done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        chk("result", {o_resp, o_tie, o_diff, o_cnt_a, o_cnt_b}, exp_q.pop_front());
      end
    end
  end

  // Gate width monitor: counts gate-high cycles and checks each completed pulse.
  int  gate_run  = 0;
  logic gate_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      gate_run  = 0;
      gate_prev = 1'b0;
    end else begin
      if (o_gate) begin
        gate_run++;
      end else if (gate_prev) begin
        if (gw_q.size() == 0) chk("unexpected_gate", 1, 0);
        else chk("gate_width", gate_run, gw_q.pop_front());
        gate_run = 0;
      end
      gate_prev = o_gate;
    end
  end

  // Driver: issue one measurement, optionally with stray start pulses while busy.
  task automatic run_meas(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic er, input logic et, input logic [DW-1:0] ed,
                          input bit noise);
    int cyc;
    cnt_a = a;
    cnt_b = b;
    exp_q.push_back({er, et, ed, a, b});
    gw_q.push_back(n);
    @(posedge clk); #1;
    start   = 1'b1;
    win_len = WW'(n);
    @(posedge clk); #1;
    start   = 1'b0;
    win_len = WW'($urandom_range(1, 100));
    @(negedge clk);
    chk("gate_at_start", o_gate, 1);
    chk("busy_at_start", o_busy, 1);
    cyc = 0;
    while (!o_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (noise && cyc < n + CS - 1) begin
        start   = 1'($urandom_range(0, 1));
        win_len = WW'($urandom_range(1, 40));
      end else begin
        start = 1'b0;
      end
    end
    chk("done_latency", cyc, n + CS);
    @(negedge clk);
    chk("done_pulse_width", o_done, 0);
    chk("busy_after_done", o_busy, 0);
  endtask

  initial begin
    int gap;
    int guard;
    bit issued;
    rst     = 1'b1;
    start   = 1'b0;
    win_len = '0;
    cnt_a   = '0;
    cnt_b   = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gate", o_gate, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_results", {o_resp, o_tie, o_diff, o_cnt_a, o_cnt_b}, 0);
    chk("rst_state", o_state, 0);
    rst = 1'b0;

    // Basic vectors.
    run_meas(10, 24'h000123, 24'h000100, 1'b1, 1'b0, 24'h000023, 1'b0);
    run_meas(3,  24'h0ABCDE, 24'h0ABCDE, 1'b0, 1'b1, 24'h000000, 1'b0);
    run_meas(5,  24'h000005, 24'hFFFFFF, 1'b0, 1'b0, 24'hFFFFFA, 1'b0);
    run_meas(1,  24'h800000, 24'h7FFFFF, 1'b1, 1'b0, 24'h000001, 1'b0);

    // Stray starts during WINDOW and SETTLE must not disturb the measurement.
    run_meas(6,  24'h000050, 24'h000060, 1'b0, 1'b0, 24'h000010, 1'b1);

    // Reset in cycle 5 of a 10-cycle window: the gate must drop without a clock edge.
    cnt_a = 24'h000777;
    cnt_b = 24'h000111;
    @(posedge clk); #1;
    start   = 1'b1;
    win_len = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_gate_before", o_gate, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_gate_async", o_gate, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_results", {o_resp, o_tie, o_diff, o_cnt_a, o_cnt_b}, 0);
    chk("abort_state", o_state, 0);
    chk("abort_win_n", o_win_n, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run_meas(10, 24'h000123, 24'h000100, 1'b1, 1'b0, 24'h000023, 1'b0);

    // A zero-length start is ignored, and the previous results hold.
    @(posedge clk); #1;
    start   = 1'b1;
    win_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("zero_len_activity", {o_gate, o_busy, o_done}, 0);
    end
    chk("zero_len_hold", {o_resp, o_cnt_a, o_cnt_b}, {1'b1, 24'h000123, 24'h000100});

    // Back-to-back start in the done cycle with N=1: the gate is low for exactly 5 cycles.
    cnt_a = 24'h000010;
    cnt_b = 24'h000020;
    exp_q.push_back({1'b0, 1'b0, 24'h000010, 24'h000010, 24'h000020});
    exp_q.push_back({1'b0, 1'b0, 24'h000010, 24'h000010, 24'h000020});
    gw_q.push_back(1);
    gw_q.push_back(1);
    @(posedge clk); #1;
    start   = 1'b1;
    win_len = 16'd1;
    @(posedge clk); #1;
    start  = 1'b0;
    gap    = 0;
    issued = 1'b0;
    guard  = 0;
    while (guard < 100) begin
      @(negedge clk);
      guard++;
      if (o_done && !issued) begin
        start   = 1'b1;
        win_len = 16'd1;
        issued  = 1'b1;
      end
      if (!o_gate) gap++;
      else if (gap > 0) break;
    end
    start = 1'b0;
    chk("b2b_restart_accepted", {issued, o_gate}, 2'b11);
    chk("b2b_gate_gap", gap, CS + 1);
    guard = 0;
    while (!o_done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("b2b_second_done", o_done, 1);
    repeat (4) @(negedge clk);

    chk("results_outstanding", exp_q.size(), 0);
    chk("gates_outstanding", gw_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
